// File: rtl/calc_ctrl_pkg.sv
// Shared encodings for the matrix-calculator top-level controller.
package calc_ctrl_pkg;

    // Controller states; the numeric values are visible on state_o.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_MENU       = 4'd1,
        ST_INPUT      = 4'd2,
        ST_GEN        = 4'd3,
        ST_DISPLAY    = 4'd4,
        ST_OP_SELECT  = 4'd5,
        ST_OP_OPERAND = 4'd6,
        ST_OP_RUN     = 4'd7,
        ST_OP_RESULT  = 4'd8,
        ST_ERROR      = 4'd9
    } state_t;

    // Datapath mode presented on mode_sel.
    typedef enum logic [1:0] {
        MODE_MENU  = 2'd0,
        MODE_INPUT = 2'd1,
        MODE_GEN   = 2'd2,
        MODE_OP    = 2'd3
    } mode_t;

    // Menu choices on sw[1:0].
    localparam logic [1:0] SEL_INPUT   = 2'd0;
    localparam logic [1:0] SEL_GEN     = 2'd1;
    localparam logic [1:0] SEL_DISPLAY = 2'd2;
    localparam logic [1:0] SEL_OP      = 2'd3;

    // Key positions on key_n.
    localparam int unsigned KEY_OK   = 0;
    localparam int unsigned KEY_BACK = 1;

    // Mode shown to the datapath while in a given state.
    function automatic mode_t mode_of(input state_t s);
        mode_t m;
        case (s)
            ST_INPUT:      m = MODE_INPUT;
            ST_GEN:        m = MODE_GEN;
            ST_DISPLAY,
            ST_OP_SELECT,
            ST_OP_OPERAND,
            ST_OP_RUN,
            ST_OP_RESULT:  m = MODE_OP;
            default:       m = MODE_MENU;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/calc_ctrl_fsm_p_key_edge_sync.sv
// Two-flop synchroniser plus history flop for one active-low key;
// emits a single-cycle pulse when the synchronised level falls.
module key_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_p
);

    logic sync1;
    logic sync2;
    logic hist;

    // Synchronise the raw key and keep one cycle of history; preset to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign press_p = hist & ~sync2;

endmodule

// File: rtl/calc_ctrl_fsm_p.sv
// Top-level control FSM for the matrix calculator: key edge detection,
// menu navigation, validated op selection, tick countdowns for the
// error hold and the operation watchdog, and one-shot datapath starts.
module calc_ctrl_fsm_p
    import calc_ctrl_pkg::*;
#(
    parameter int unsigned OP_W        = 3,
    parameter int unsigned NUM_OPS     = 5,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned ERR_HOLD    = 5,
    parameter int unsigned RUN_TIMEOUT = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W+1:0]   sw,
    input  logic [1:0]        key_n,
    input  logic              error_flag,
    input  logic              busy_flag,
    input  logic              done_flag,
    output logic [1:0]        mode_sel,
    output logic [OP_W-1:0]   op_sel,
    output logic [CNT_W-1:0]  countdown_val,
    output logic              start_input,
    output logic              start_gen,
    output logic              start_disp,
    output logic              start_op,
    output logic              tx_start,
    output logic [3:0]        state_o
);

    localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    state_t              state;
    state_t              next_state;
    logic                ok_p;
    logic                back_p;
    logic [PRE_W-1:0]    presc;
    logic                running;
    logic                tick;
    logic                op_legal;
    logic [OP_W-1:0]     op_code;
    logic [1:0]          menu_sel;
    logic [CNT_W-1:0]    cnt_next;
    logic [OP_W-1:0]     op_next;

    key_edge_sync u_key_ok (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n   (key_n[KEY_OK]),
        .press_p (ok_p)
    );

    key_edge_sync u_key_back (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n   (key_n[KEY_BACK]),
        .press_p (back_p)
    );

    assign menu_sel = sw[1:0];
    assign op_code  = sw[OP_W+1:2];
    assign op_legal = (32'(op_code) < NUM_OPS);
    assign running  = (state == ST_OP_RUN) || (state == ST_ERROR);
    assign tick     = running && (presc == PRE_W'(TICK_DIV - 1));
    assign state_o  = state;

    // Next-state selection; error_flag beats BACK beats OK/done where it applies.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: next_state = ST_MENU;
            ST_MENU: begin
                if (error_flag)  next_state = ST_ERROR;
                else if (back_p) next_state = ST_MENU;
                else if (ok_p) begin
                    case (menu_sel)
                        SEL_INPUT:   next_state = ST_INPUT;
                        SEL_GEN:     next_state = ST_GEN;
                        SEL_DISPLAY: next_state = ST_DISPLAY;
                        default:     next_state = ST_OP_SELECT;
                    endcase
                end
            end
            ST_INPUT, ST_DISPLAY: begin
                if (error_flag)  next_state = ST_ERROR;
                else if (back_p) next_state = ST_MENU;
            end
            ST_GEN: begin
                if (error_flag)                next_state = ST_ERROR;
                else if (back_p || done_flag)  next_state = ST_MENU;
            end
            ST_OP_SELECT: begin
                if (error_flag)            next_state = ST_ERROR;
                else if (back_p)           next_state = ST_MENU;
                else if (ok_p && op_legal) next_state = ST_OP_OPERAND;
            end
            ST_OP_OPERAND: begin
                if (error_flag)  next_state = ST_ERROR;
                else if (back_p) next_state = ST_MENU;
                else if (ok_p)   next_state = ST_OP_RUN;
            end
            ST_OP_RUN: begin
                if (error_flag)     next_state = ST_ERROR;
                else if (done_flag) next_state = ST_OP_RESULT;
                else if ((countdown_val == '0) && (busy_flag || !done_flag))
                    next_state = ST_ERROR;
            end
            ST_OP_RESULT: begin
                if (ok_p || back_p) next_state = ST_MENU;
            end
            ST_ERROR: begin
                if (back_p)                    next_state = ST_MENU;
                else if (countdown_val == '0)  next_state = ST_MENU;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Countdown and op latch values for the next cycle.
    always_comb begin
        cnt_next = '0;
        if ((next_state == ST_OP_RUN) && (state != ST_OP_RUN))
            cnt_next = CNT_W'(RUN_TIMEOUT);
        else if ((next_state == ST_ERROR) && (state != ST_ERROR))
            cnt_next = CNT_W'(ERR_HOLD);
        else if ((next_state == state) && running)
            cnt_next = (tick && (countdown_val != '0)) ? countdown_val - CNT_W'(1)
                                                       : countdown_val;
        op_next = op_sel;
        if ((state == ST_OP_SELECT) && (next_state == ST_OP_OPERAND))
            op_next = op_code;
    end

    // State, prescaler and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            presc         <= '0;
            countdown_val <= '0;
            op_sel        <= '0;
            mode_sel      <= '0;
            start_input   <= 1'b0;
            start_gen     <= 1'b0;
            start_disp    <= 1'b0;
            start_op      <= 1'b0;
            tx_start      <= 1'b0;
        end else begin
            state         <= next_state;
            presc         <= ((next_state != state) || !running || tick) ? '0 : presc + 1'b1;
            countdown_val <= cnt_next;
            op_sel        <= op_next;
            mode_sel      <= mode_of(next_state);
            start_input   <= (next_state == ST_INPUT)     && (state != ST_INPUT);
            start_gen     <= (next_state == ST_GEN)       && (state != ST_GEN);
            start_disp    <= (next_state == ST_DISPLAY)   && (state != ST_DISPLAY);
            start_op      <= (next_state == ST_OP_RUN)    && (state != ST_OP_RUN);
            tx_start      <= (next_state == ST_OP_RESULT) && (state != ST_OP_RESULT);
        end
    end

endmodule

// File: tb/tb_calc_ctrl_fsm_p.sv
// Scoreboard bench for calc_ctrl_fsm_p with a transaction-level model.
module tb_calc_ctrl_fsm_p;

    localparam int OP_W        = 3;
    localparam int NUM_OPS     = 5;
    localparam int CNT_W       = 8;
    localparam int TICK_DIV    = 4;
    localparam int ERR_HOLD    = 5;
    localparam int RUN_TIMEOUT = 3;

    localparam int S_IDLE = 0, S_MENU = 1, S_INPUT = 2, S_GEN = 3, S_DISP = 4,
                   S_OPSEL = 5, S_OPND = 6, S_RUN = 7, S_RES = 8, S_ERR = 9;

    typedef logic [OP_W+1:0] sw_t;
    typedef struct { int kind; int st; int op; } ev_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    sw_t              sw = '0;
    logic [1:0]       key_n = 2'b11;
    logic             error_flag = 1'b0;
    logic             busy_flag = 1'b0;
    logic             done_flag = 1'b0;
    logic [1:0]       mode_sel;
    logic [OP_W-1:0]  op_sel;
    logic [CNT_W-1:0] countdown_val;
    logic             start_input, start_gen, start_disp, start_op, tx_start;
    logic [3:0]       state_o;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  m_state = S_IDLE;
    int  m_op = 0;

    calc_ctrl_fsm_p #(
        .OP_W(OP_W), .NUM_OPS(NUM_OPS), .CNT_W(CNT_W),
        .TICK_DIV(TICK_DIV), .ERR_HOLD(ERR_HOLD), .RUN_TIMEOUT(RUN_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .key_n(key_n),
        .error_flag(error_flag), .busy_flag(busy_flag), .done_flag(done_flag),
        .mode_sel(mode_sel), .op_sel(op_sel), .countdown_val(countdown_val),
        .start_input(start_input), .start_gen(start_gen), .start_disp(start_disp),
        .start_op(start_op), .tx_start(tx_start), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mode_of(input int s);
        case (s)
            S_INPUT: return 1;
            S_GEN:   return 2;
            S_DISP, S_OPSEL, S_OPND, S_RUN, S_RES: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic void push(input int kind);
        ev_t e;
        e.kind = kind; e.st = m_state; e.op = m_op;
        exp_q.push_back(e);
    endfunction

    // Monitor: every start pulse must match the next expected event.
    always @(negedge clk) begin : mon
        int n;
        int kind;
        ev_t e;
        if (rst_n) begin
            n = int'(start_input) + int'(start_gen) + int'(start_disp) + int'(start_op) + int'(tx_start);
            if (n != 0) begin
                chk("pulse_count", n, 1);
                if (start_input)     kind = 0;
                else if (start_gen)  kind = 1;
                else if (start_disp) kind = 2;
                else if (start_op)   kind = 3;
                else                 kind = 4;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_pulse: got kind %0d expected none (t=%0t)", kind, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", kind, e.kind);
                    chk("pulse_state", int'(state_o), e.st);
                    chk("pulse_mode", int'(mode_sel), mode_of(e.st));
                    chk("pulse_op", int'(op_sel), e.op);
                end
            end
        end
    end

    task automatic expect_state(input string tag);
        chk({tag, "/state"}, int'(state_o), m_state);
        chk({tag, "/mode"}, int'(mode_sel), mode_of(m_state));
        chk({tag, "/op_sel"}, int'(op_sel), m_op);
        if (m_state != S_RUN && m_state != S_ERR)
            chk({tag, "/countdown"}, int'(countdown_val), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "/state"}, int'(state_o), 0);
        chk({tag, "/mode"}, int'(mode_sel), 0);
        chk({tag, "/op_sel"}, int'(op_sel), 0);
        chk({tag, "/countdown"}, int'(countdown_val), 0);
        chk({tag, "/pulses"}, int'({start_input, start_gen, start_disp, start_op, tx_start}), 0);
    endtask

    // Keys idle 3 cycles first; the effect lands on the 3rd rising edge after the fall.
    task automatic press(input logic [1:0] mask, input int hold);
        repeat (3) @(negedge clk);
        key_n = ~mask;
        repeat (3) @(posedge clk);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        key_n = 2'b11;
    endtask

    task automatic do_ok(input sw_t swv, input int hold);
        int h;
        h = hold;
        sw = swv;
        case (m_state)
            S_MENU: begin
                case (int'(swv[1:0]))
                    0: begin m_state = S_INPUT; push(0); end
                    1: begin m_state = S_GEN;   push(1); end
                    2: begin m_state = S_DISP;  push(2); end
                    default: m_state = S_OPSEL;
                endcase
            end
            S_OPSEL: if (int'(swv[OP_W+1:2]) < NUM_OPS) begin
                m_op = int'(swv[OP_W+1:2]);
                m_state = S_OPND;
            end
            S_OPND: begin m_state = S_RUN; push(3); end
            S_RES:  m_state = S_MENU;
            default: ;
        endcase
        if (m_state == S_RUN || m_state == S_ERR) h = 0;
        press(2'b01, h);
    endtask

    task automatic do_back(input logic [1:0] mask, input int hold);
        int h;
        h = hold;
        if (m_state != S_MENU && m_state != S_RUN && m_state != S_IDLE) m_state = S_MENU;
        if (m_state == S_RUN) h = 0;
        press(mask, h);
    endtask

    task automatic do_done();
        if (m_state == S_GEN) m_state = S_MENU;
        else if (m_state == S_RUN) begin m_state = S_RES; push(4); end
        done_flag = 1'b1;
        @(negedge clk);
        done_flag = 1'b0;
    endtask

    task automatic do_err();
        if (m_state >= S_MENU && m_state <= S_RUN) m_state = S_ERR;
        error_flag = 1'b1;
        @(negedge clk);
        error_flag = 1'b0;
    endtask

    // Called on the falling edge right after ERROR was entered.
    task automatic err_resolve(input int choice);
        chk("err_load", int'(countdown_val), ERR_HOLD);
        if (choice == 2) begin
            do_back($urandom_range(0, 1) != 0 ? 2'b11 : 2'b10, 0);
            expect_state("err_back");
        end else begin
            if (choice == 1) error_flag = 1'b1;
            for (int k = 1; k <= ERR_HOLD; k++) begin
                repeat (TICK_DIV) @(negedge clk);
                chk("err_count", int'(countdown_val), ERR_HOLD - k);
                chk("err_state", int'(state_o), S_ERR);
            end
            @(negedge clk);
            m_state = S_MENU;
            expect_state("err_auto");
            error_flag = 1'b0;
        end
    endtask

    // Called on the falling edge right after OP_RUN was entered.
    task automatic run_resolve(input int choice, input int err_choice);
        chk("run_load", int'(countdown_val), RUN_TIMEOUT);
        case (choice)
            0: begin
                for (int k = 1; k <= RUN_TIMEOUT; k++) begin
                    repeat (TICK_DIV) @(negedge clk);
                    chk("run_count", int'(countdown_val), RUN_TIMEOUT - k);
                    chk("run_state", int'(state_o), S_RUN);
                end
                @(negedge clk);
                m_state = S_ERR;
                expect_state("run_timeout");
                err_resolve(err_choice);
            end
            1: begin do_done(); expect_state("run_done"); end
            2: begin do_err(); expect_state("run_err"); err_resolve(err_choice); end
            3: begin
                do_back(2'b10, 0);
                expect_state("run_back_ignored");
                do_done();
                expect_state("run_done2");
            end
            default: begin
                repeat (TICK_DIV * RUN_TIMEOUT) @(negedge clk);
                chk("run_zero", int'(countdown_val), 0);
                do_done();
                expect_state("run_done_at_zero");
            end
        endcase
    endtask

    function automatic sw_t mk_sw(input int code, input int sel);
        sw_t v;
        v = sw_t'((code << 2) | sel);
        return v;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        int r;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        #1 chk("post_reset_idle", int'(state_o), S_IDLE);
        @(negedge clk);
        m_state = S_MENU;
        expect_state("menu_after_reset");

        do_ok(mk_sw(0, 1), 100);
        expect_state("gen_held");
        do_done();
        expect_state("gen_done");

        do_ok(mk_sw(0, 3), 0);
        expect_state("opsel");
        do_ok(mk_sw(6, 3), 0);
        expect_state("opsel_illegal");
        do_ok(mk_sw(2, 3), 0);
        expect_state("operand");
        do_ok(mk_sw(2, 3), 0);
        expect_state("run");
        run_resolve(0, 1);

        do_err();
        expect_state("menu_err");
        err_resolve(2);

        do_ok(mk_sw(1, 3), 0);
        do_ok(mk_sw(1, 3), 0);
        expect_state("operand2");
        do_back(2'b11, 0);
        expect_state("both_keys");

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 5);
            case (r)
                0, 1: do_ok(sw_t'($urandom), $urandom_range(0, 20));
                2:    do_back(2'b10, $urandom_range(0, 20));
                3:    do_back(2'b11, 0);
                4:    do_done();
                default: do_err();
            endcase
            expect_state("rand");
            if (m_state == S_RUN)
                run_resolve($urandom_range(0, 4), $urandom_range(0, 2));
            else if (m_state == S_ERR)
                err_resolve($urandom_range(0, 2));
        end

        if (m_state != S_MENU) begin
            do_back(2'b10, 0);
            expect_state("to_menu");
        end
        do_ok(mk_sw(4, 3), 0);
        do_ok(mk_sw(4, 3), 0);
        do_ok(mk_sw(4, 3), 0);
        expect_state("run_before_reset");
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        m_state = S_IDLE;
        m_op = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_state = S_MENU;
        expect_state("menu_after_reset2");

        repeat (5) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_ctrl_fsm_p.md
Name: calc_ctrl_fsm_p

Overview:
Parametrised top-level control FSM for the matrix calculator. It replaces the fixed menu controller and adds:
- on-chip key synchronisation and press-edge detection
- a validated, width-generic operation selector
- a tick-driven countdown that auto-exits the error state
- a watchdog on operation runs
It sits between the board switch/key inputs and the input/generate/display/operate/UART-tx datapath blocks.

Parameters:
OP_W, 3, width of op_sel; op code taken from sw[OP_W+1:2]
NUM_OPS, 5, number of legal op codes (0..NUM_OPS-1); codes >= NUM_OPS are rejected
CNT_W, 8, width of countdown_val and tick counters
TICK_DIV, 50_000_000, clk cycles per countdown tick (>=2)
ERR_HOLD, 5, ticks spent in ERROR before automatic return to MENU (>=1)
RUN_TIMEOUT, 10, ticks allowed in OP_RUN before forced ERROR (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
sw  in  OP_W+2  sw[1:0] mode select, sw[OP_W+1:2] op code
key_n  in  2  raw active-low keys: [0]=OK, [1]=BACK
error_flag  in  1  datapath error, level
busy_flag  in  1  datapath busy, level
done_flag  in  1  datapath done, pulse or level
mode_sel  out  2  0 menu/error, 1 input, 2 gen, 3 display/op
op_sel  out  OP_W  latched legal op code
countdown_val  out  CNT_W  remaining ticks (ERROR or OP_RUN), else 0
start_input, start_gen, start_disp, start_op, tx_start  out  1 each  one-cycle start pulses
state_o  out  4  current state encoding, for debug/LED

Behaviour:
Reset:
- state=IDLE; all outputs 0; synchronisers preset to 1 (released); prescaler and counters 0.
- Reset mid-operation aborts immediately with no pulses.

Keys:
- Each key_n bit passes through a 2-flop synchroniser, then a 1-flop history stage.
- ok_p/back_p is high for exactly one cycle when the synchronised level goes 1->0.
- Latency: the pulse is visible on the 3rd rising edge after key_n falls.
- A held key gives a single pulse.

Tick:
- Prescaler runs only in ERROR and OP_RUN.
- It clears on every state change.
- tick pulses once every TICK_DIV cycles.

States: IDLE=0, MENU=1, INPUT=2, GEN=3, DISPLAY=4, OP_SELECT=5, OP_OPERAND=6, OP_RUN=7, OP_RESULT=8, ERROR=9. Unused encodings go to IDLE.

Priority in every state except IDLE, OP_RESULT and ERROR: error_flag > back_p > ok_p/done. If ok_p and back_p arrive in the same cycle, BACK wins.

Transitions:
- IDLE -> MENU unconditionally.
- MENU, on ok_p, by sw[1:0]: 0->INPUT, 1->GEN, 2->DISPLAY, 3->OP_SELECT.
- INPUT, DISPLAY: back_p -> MENU.
- GEN: done_flag or back_p -> MENU.
- OP_SELECT: ok_p with sw code < NUM_OPS -> latch op_sel, go to OP_OPERAND. An illegal code is ignored; stay, op_sel unchanged.
- OP_OPERAND: ok_p -> OP_RUN; back_p -> MENU.
- OP_RUN:
  - countdown_val loads RUN_TIMEOUT on entry and decrements on tick.
  - done_flag -> OP_RESULT, even in the same cycle countdown reaches 0.
  - countdown 0 with busy_flag or !done -> ERROR.
  - back_p is ignored here.
- OP_RESULT: ok_p or back_p -> MENU; error_flag is ignored.
- ERROR:
  - countdown_val loads ERR_HOLD on entry and decrements on tick.
  - back_p -> MENU immediately.
  - countdown reaching 0 -> MENU, even if error_flag is still high.
  - error_flag falling does NOT exit early.

Outputs (registered from next_state, so they are valid in the same cycle as the new state):
- start_* and tx_start pulse for one cycle on entry to INPUT, GEN, DISPLAY, OP_RUN and OP_RESULT respectively. They never pulse on self-loops.
- mode_sel follows the state table.
- countdown_val is 0 outside ERROR and OP_RUN, and saturates at 0 (no wrap).
- op_sel holds its value across MENU.

Decomposition:
- Package calc_ctrl_pkg: state encodings, mode_sel codes, key index constants.
- Sub-module key_edge_sync: per-key synchroniser plus falling-edge pulse, instantiated 2x. Prescaler stays inline.

Test Plan:
1. Reset released, keys high -> state IDLE then MENU on next cycle; all outputs 0; no start pulse.
2. sw=2'b01, key_n[0] held low for 100 cycles -> exactly one start_gen pulse; state GEN; then done_flag=1 -> MENU.
3. NUM_OPS=5, op code 6 with OK in OP_SELECT -> stays in OP_SELECT, op_sel unchanged. Op code 2 with OK -> op_sel=2, state OP_OPERAND.
4. TICK_DIV=4, RUN_TIMEOUT=3: OP_RUN with no done -> countdown_val 3,2,1,0 at 4-cycle spacing, then ERROR with countdown_val=ERR_HOLD.
5. In ERROR with error_flag held 1 -> auto-return to MENU after ERR_HOLD ticks. Repeat with a back_p press -> MENU in 1 cycle.
6. OK and BACK pressed in the same cycle in OP_OPERAND -> MENU, no start_op. rst_n asserted during OP_RUN -> all outputs 0 asynchronously.
